// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: controller for a 2-way set-associative, one-word-per-line cache.
// Write-back and write-allocate, with 1-bit LRU per set. Misses use a req/ack memory
// bus: the dirty victim is written back first, then the missed word is fetched.
// Optional feature macro: CACHE_STATS_EN adds hit/miss/writeback counters.
// Without it, stat_* are tied to zero.
module cache_ctrl_2way #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 6,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req,
    input  logic                              cpu_we,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]             cpu_wdata,
    output logic                              cpu_ready,
    output logic                              cpu_done,
    output logic [DATA_WIDTH-1:0]             cpu_rdata,
    output logic [INDEX_WIDTH-1:0]            arr_index,
    output logic [TAG_WIDTH-1:0]              arr_tag,
    output logic                              arr_we,
    output logic                              arr_way_sel,
    output logic [DATA_WIDTH-1:0]             arr_din,
    output logic                              arr_valid_in,
    output logic                              arr_dirty_in,
    input  logic                              arr_hit,
    input  logic                              arr_hit_way,
    input  logic [DATA_WIDTH-1:0]             arr_dout,
    input  logic                              arr_sel_valid,
    input  logic                              arr_sel_dirty,
    input  logic [TAG_WIDTH-1:0]              arr_sel_tag,
    input  logic [DATA_WIDTH-1:0]             arr_sel_data,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_ack,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [31:0]                       stat_hits,
    output logic [31:0]                       stat_misses,
    output logic [31:0]                       stat_wbacks
);
    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;
    localparam int LINE_NUM   = 1 << INDEX_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  victim_q, victim_d;
    logic [TAG_WIDTH-1:0]  victim_tag_q, victim_tag_d;
    logic [DATA_WIDTH-1:0] victim_data_q, victim_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [LINE_NUM-1:0]   lru_q, lru_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  cpu_done_q, cpu_done_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;

    logic [INDEX_WIDTH-1:0] idx_s;
    logic                   ack_s;

    // An ack only counts while a request is actually outstanding.
    assign ack_s = mem_ack & mem_req_q;
    assign idx_s = addr_q[INDEX_WIDTH-1:0];

    assign arr_index = idx_s;
    assign arr_tag   = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = (state_q == S_WB) ? {victim_tag_q, idx_s} : addr_q;
    assign mem_wdata = victim_data_q;

    // Next-state, array drive and bookkeeping for the lookup/writeback/refill sequence.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        victim_d      = victim_q;
        victim_tag_d  = victim_tag_q;
        victim_data_d = victim_data_q;
        rdata_d       = rdata_q;
        lru_d         = lru_q;
        arr_we        = 1'b0;
        arr_way_sel   = victim_q;
        arr_din       = wdata_q;
        arr_valid_in  = 1'b0;
        arr_dirty_in  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (arr_hit) begin
                    arr_way_sel  = arr_hit_way;
                    lru_d[idx_s] = ~arr_hit_way;
                    if (we_q) begin
                        arr_we       = 1'b1;
                        arr_din      = wdata_q;
                        arr_valid_in = 1'b1;
                        arr_dirty_in = 1'b1;
                    end else begin
                        rdata_d = arr_dout;
                    end
                    state_d = S_RESP;
                end else begin
                    arr_way_sel   = lru_q[idx_s];
                    victim_d      = lru_q[idx_s];
                    victim_tag_d  = arr_sel_tag;
                    victim_data_d = arr_sel_data;
                    if (arr_sel_valid && arr_sel_dirty) begin
                        state_d = S_WB;
                    end else if (!we_q) begin
                        state_d = S_REFILL;
                    end else begin
                        // Whole line is one word, so a write miss installs without a fetch.
                        arr_we       = 1'b1;
                        arr_din      = wdata_q;
                        arr_valid_in = 1'b1;
                        arr_dirty_in = 1'b1;
                        lru_d[idx_s] = ~lru_q[idx_s];
                        state_d      = S_RESP;
                    end
                end
            end
            S_WB: begin
                if (ack_s && !we_q) begin
                    state_d = S_REFILL;
                end else if (ack_s) begin
                    arr_we       = 1'b1;
                    arr_din      = wdata_q;
                    arr_valid_in = 1'b1;
                    arr_dirty_in = 1'b1;
                    lru_d[idx_s] = ~victim_q;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_WB;
                end
            end
            S_REFILL: begin
                if (ack_s) begin
                    arr_we       = 1'b1;
                    arr_din      = mem_rdata;
                    arr_valid_in = 1'b1;
                    arr_dirty_in = 1'b0;
                    rdata_d      = mem_rdata;
                    lru_d[idx_s] = ~victim_q;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Request drops the cycle after an ack, so WB->REFILL leaves a one-cycle gap.
        mem_req_d   = ((state_d == S_WB) || (state_d == S_REFILL)) && !ack_s;
        mem_we_d    = (state_d == S_WB) && mem_req_d;
        cpu_ready_d = (state_d == S_IDLE);
        cpu_done_d  = (state_d == S_RESP);
    end

    // State, request context and handshake output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            victim_q      <= 1'b0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            rdata_q       <= '0;
            lru_q         <= '0;
            cpu_ready_q   <= 1'b1;
            cpu_done_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            victim_q      <= victim_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            rdata_q       <= rdata_d;
            lru_q         <= lru_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_done_q    <= cpu_done_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic [31:0] wbacks_q, wbacks_d;

    // Wrapping event counters: one lookup outcome per request, one per finished writeback.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        wbacks_d = wbacks_q;
        if ((state_q == S_LOOKUP) && arr_hit) begin
            hits_d = hits_q + 32'd1;
        end else if (state_q == S_LOOKUP) begin
            misses_d = misses_q + 32'd1;
        end else begin
            hits_d = hits_q;
        end
        if ((state_q == S_WB) && ack_s) begin
            wbacks_d = wbacks_q + 32'd1;
        end else begin
            wbacks_d = wbacks_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= 32'd0;
            misses_q <= 32'd0;
            wbacks_q <= 32'd0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbacks_q <= wbacks_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_wbacks = wbacks_q;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
    assign stat_wbacks = 32'd0;
`endif

endmodule
